// File: rtl/mdu_hilo_ctrl_pkg.sv
// Shared encodings for the MDU HI/LO controller: op codes, FSM states,
// divider iteration count and an operand magnitude helper.
package mdu_hilo_ctrl_pkg;

    localparam int DIV_CYCLES = 32;

    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MTHI  = 3'd4,
        OP_MTLO  = 3'd5,
        OP_RSV6  = 3'd6,
        OP_RSV7  = 3'd7
    } mdu_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_DIV  = 1'b1
    } mdu_state_e;

    // 0x80000000 maps to itself, which is the correct unsigned magnitude.
    function automatic logic [31:0] mag32(input logic [31:0] x, input logic is_signed);
        return (is_signed && x[31]) ? (32'd0 - x) : x;
    endfunction

endpackage

// File: rtl/mdu_div_core.sv
// Iterative restoring radix-2 divider: one quotient bit per cycle on operand
// magnitudes, with sign fix-up and divide-by-zero override on the result.
module mdu_div_core
    import mdu_hilo_ctrl_pkg::*;
#(
    parameter int ITERS = DIV_CYCLES
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic        abort_i,
    input  logic        signed_i,
    input  logic [31:0] dividend_i,
    input  logic [31:0] divisor_i,
    output logic        done_o,
    output logic [31:0] quot_o,
    output logic [31:0] rem_o
);

    localparam int CW = $clog2(ITERS + 1);

    logic          busy_q;
    logic [CW-1:0] cnt_q;
    logic [31:0]   dvsr_q;
    logic [31:0]   rem_q;
    logic [31:0]   quo_q;
    logic [31:0]   a_raw_q;
    logic          neg_quo_q;
    logic          neg_rem_q;
    logic          dbz_q;

    logic [32:0]   partial;
    logic [32:0]   diff;
    logic [31:0]   rem_d;
    logic [31:0]   quo_d;

    // Dividend shifts out of quo_q MSB-first while quotient bits shift in.
    always_comb begin
        partial = {rem_q, quo_q[31]};
        diff    = partial - {1'b0, dvsr_q};
        if (diff[32]) begin
            rem_d = partial[31:0];
            quo_d = {quo_q[30:0], 1'b0};
        end else begin
            rem_d = diff[31:0];
            quo_d = {quo_q[30:0], 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q    <= 1'b0;
            cnt_q     <= '0;
            dvsr_q    <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            a_raw_q   <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            dbz_q     <= 1'b0;
        end else if (abort_i) begin
            busy_q <= 1'b0;
        end else if (start_i) begin
            busy_q    <= 1'b1;
            cnt_q     <= '0;
            dvsr_q    <= mag32(divisor_i, signed_i);
            quo_q     <= mag32(dividend_i, signed_i);
            rem_q     <= '0;
            a_raw_q   <= dividend_i;
            neg_quo_q <= signed_i && (dividend_i[31] ^ divisor_i[31]);
            neg_rem_q <= signed_i && dividend_i[31];
            dbz_q     <= (divisor_i == 32'd0);
        end else if (busy_q) begin
            rem_q <= rem_d;
            quo_q <= quo_d;
            cnt_q <= cnt_q + CW'(1);
            if (done_o) begin
                busy_q <= 1'b0;
            end
        end
    end

    // Results are presented from the final step's next-state so the caller
    // can capture them on the same edge that completes the last iteration.
    assign done_o = busy_q && (cnt_q == CW'(ITERS - 1));
    assign quot_o = dbz_q ? 32'hFFFF_FFFF : (neg_quo_q ? (32'd0 - quo_d) : quo_d);
    assign rem_o  = dbz_q ? a_raw_q       : (neg_rem_q ? (32'd0 - rem_d) : rem_d);

endmodule

// File: rtl/mdu_hilo_ctrl.sv
// MDU HI/LO controller: single-cycle MULT/MULTU/MTHI/MTLO, iterative DIV/DIVU.
// State table: ST_IDLE | accepting requests ; ST_DIV | divider running, stall held
module mdu_hilo_ctrl #(
    parameter int DIV_CYCLES = mdu_hilo_ctrl_pkg::DIV_CYCLES
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        flush,
    output logic        stall_req,
    output logic        done,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o
);

    import mdu_hilo_ctrl_pkg::*;

    mdu_state_e  state_q;
    logic [31:0] hi_q;
    logic [31:0] lo_q;
    logic        done_q;

    mdu_op_e     op_e;
    logic        op_valid;
    logic        accept;
    logic        div_accept;
    logic        mul_signed;
    logic [63:0] mul_a;
    logic [63:0] mul_b;
    logic [63:0] prod;

    logic        core_done;
    logic [31:0] core_quot;
    logic [31:0] core_rem;

    assign op_e       = mdu_op_e'(op);
    assign op_valid   = (op_e != OP_RSV6) && (op_e != OP_RSV7);
    assign accept     = start && !flush && (state_q == ST_IDLE) && op_valid;
    assign div_accept = accept && ((op_e == OP_DIV) || (op_e == OP_DIVU));
    assign stall_req  = (state_q == ST_DIV) || div_accept;

    // Sign-extend to 64 bits; the low 64 bits of the product are then exact for both modes.
    assign mul_signed = (op_e == OP_MULT);
    assign mul_a      = {{32{mul_signed & src_a[31]}}, src_a};
    assign mul_b      = {{32{mul_signed & src_b[31]}}, src_b};
    assign prod       = mul_a * mul_b;

    mdu_div_core #(
        .ITERS (DIV_CYCLES)
    ) u_div_core (
        .clk        (clk),
        .rst        (rst),
        .start_i    (div_accept),
        .abort_i    (flush),
        .signed_i   (op_e == OP_DIV),
        .dividend_i (src_a),
        .divisor_i  (src_b),
        .done_o     (core_done),
        .quot_o     (core_quot),
        .rem_o      (core_rem)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        case (op_e)
                            OP_MULT, OP_MULTU: {hi_q, lo_q} <= prod;
                            OP_MTHI:           hi_q <= src_a;
                            OP_MTLO:           lo_q <= src_a;
                            OP_DIV, OP_DIVU:   state_q <= ST_DIV;
                            default: ;
                        endcase
                    end
                end
                ST_DIV: begin
                    if (flush) begin
                        state_q <= ST_IDLE;
                    end else if (core_done) begin
                        hi_q    <= core_rem;
                        lo_q    <= core_quot;
                        done_q  <= 1'b1;
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign hi_o = hi_q;
    assign lo_o = lo_q;
    assign done = done_q;

endmodule

// File: tb/tb_mdu_hilo_ctrl.sv
// Self-checking bench for mdu_hilo_ctrl: directed corner cases plus random
// transactions compared against an arithmetic reference model.
module tb_mdu_hilo_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        flush;
    logic        stall_req;
    logic        done;
    logic [31:0] hi_o;
    logic [31:0] lo_o;

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] m_hi;
    logic [31:0] m_lo;

    mdu_hilo_ctrl #(.DIV_CYCLES(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .op        (op),
        .src_a     (src_a),
        .src_b     (src_b),
        .flush     (flush),
        .stall_req (stall_req),
        .done      (done),
        .hi_o      (hi_o),
        .lo_o      (lo_o)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] model_mul(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        longint      sa;
        longint      sb;
        longint      sp;
        logic [63:0] ua;
        logic [63:0] ub;
        if (o == 3'd0) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            sp = sa * sb;
            return 64'(sp);
        end
        ua = {32'd0, a};
        ub = {32'd0, b};
        return ua * ub;
    endfunction

    // Returns {hi, lo} = {remainder, quotient}; 64-bit arithmetic keeps the
    // signed overflow case well defined.
    function automatic logic [63:0] model_div(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        longint sa;
        longint sb;
        longint q;
        longint r;
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (o == 3'd2) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'({32'd0, a});
            sb = longint'({32'd0, b});
        end
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    task automatic finish_div(input string tag, input logic [2:0] o, input logic [31:0] a,
                              input logic [31:0] b, input int cycles_so_far);
        int   cyc;
        logic early;
        cyc   = cycles_so_far;
        early = 1'b0;
        while (stall_req === 1'b1 && cyc < 40) begin
            if (done !== 1'b0) early = 1'b1;
            cyc++;
            tick();
        end
        chk({tag, "_stall_cycles"}, 32'(cyc), 32'd33);
        chk({tag, "_early_done"}, {31'd0, early}, 32'd0);
        {m_hi, m_lo} = model_div(o, a, b);
        chk({tag, "_done"}, {31'd0, done}, 32'd1);
        chk({tag, "_hi"}, hi_o, m_hi);
        chk({tag, "_lo"}, lo_o, m_lo);
        tick();
        chk({tag, "_done_clr"}, {31'd0, done}, 32'd0);
    endtask

    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b, input string tag);
        logic is_div;
        is_div = (o == 3'd2) || (o == 3'd3);
        start = 1'b1; op = o; src_a = a; src_b = b;
        #1;
        chk({tag, "_stall_acc"}, {31'd0, stall_req}, {31'd0, is_div});
        tick();
        start = 1'b0;
        case (o)
            3'd0, 3'd1: {m_hi, m_lo} = model_mul(o, a, b);
            3'd4:       m_hi = a;
            3'd5:       m_lo = a;
            default: ;
        endcase
        if (is_div) begin
            finish_div(tag, o, a, b, 1);
        end else begin
            chk({tag, "_stall"}, {31'd0, stall_req}, 32'd0);
            chk({tag, "_done"}, {31'd0, done}, 32'd0);
            chk({tag, "_hi"}, hi_o, m_hi);
            chk({tag, "_lo"}, lo_o, m_lo);
        end
    endtask

    initial begin
        logic        seen;
        logic [2:0]  r_op;
        logic [31:0] r_a;
        logic [31:0] r_b;

        rst = 1'b1; start = 1'b0; op = 3'd0; src_a = '0; src_b = '0; flush = 1'b0;
        repeat (2) tick();
        chk("rst_hi", hi_o, 32'd0);
        chk("rst_lo", lo_o, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_stall", {31'd0, stall_req}, 32'd0);
        rst = 1'b0;
        m_hi = '0;
        m_lo = '0;

        issue(3'd1, 32'hFFFF_FFFF, 32'd2, "multu_max");
        chk("multu_max_hi_const", hi_o, 32'h0000_0001);
        chk("multu_max_lo_const", lo_o, 32'hFFFF_FFFE);
        issue(3'd0, 32'hFFFF_FFFD, 32'd7, "mult_neg");

        issue(3'd2, 32'hFFFF_FFF9, 32'd2, "div_m7_2");
        chk("div_m7_2_lo_const", lo_o, 32'hFFFF_FFFD);
        chk("div_m7_2_hi_const", hi_o, 32'hFFFF_FFFF);
        issue(3'd3, 32'd100, 32'd0, "divu_by0");
        chk("divu_by0_hi_const", hi_o, 32'd100);
        chk("divu_by0_lo_const", lo_o, 32'hFFFF_FFFF);
        issue(3'd2, 32'hFFFF_FF00, 32'd0, "div_by0_neg");
        issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
        chk("div_ovf_lo_const", lo_o, 32'h8000_0000);
        chk("div_ovf_hi_const", hi_o, 32'd0);
        issue(3'd2, 32'd17, 32'hFFFF_FFFB, "div_pos_neg");

        issue(3'd4, 32'hA5A5_A5A5, 32'd0, "mthi");
        issue(3'd5, 32'h5A5A_5A5A, 32'd0, "mtlo");
        chk("mthi_mtlo_hi", hi_o, 32'hA5A5_A5A5);
        chk("mthi_mtlo_lo", lo_o, 32'h5A5A_5A5A);
        issue(3'd6, 32'h1234_5678, 32'd3, "rsv6");
        issue(3'd7, 32'h1234_5678, 32'd3, "rsv7");

        // Same-cycle flush cancels a DIV request.
        start = 1'b1; op = 3'd2; src_a = 32'd50; src_b = 32'd5; flush = 1'b1;
        #1;
        chk("flush_acc_stall", {31'd0, stall_req}, 32'd0);
        tick();
        start = 1'b0; flush = 1'b0;
        chk("flush_acc_stall_after", {31'd0, stall_req}, 32'd0);

        // Flush at DIV cycle 10 leaves HI/LO untouched.
        issue(3'd4, 32'h11, 32'd0, "pre_hi");
        issue(3'd5, 32'h22, 32'd0, "pre_lo");
        start = 1'b1; op = 3'd2; src_a = 32'd1000; src_b = 32'd7;
        tick();
        start = 1'b0;
        repeat (9) tick();
        flush = 1'b1;
        #1;
        chk("flush_div_stall_hold", {31'd0, stall_req}, 32'd1);
        tick();
        flush = 1'b0;
        chk("flush_div_stall", {31'd0, stall_req}, 32'd0);
        chk("flush_div_done", {31'd0, done}, 32'd0);
        chk("flush_div_hi", hi_o, 32'h11);
        chk("flush_div_lo", lo_o, 32'h22);
        seen = 1'b0;
        repeat (40) begin
            if (done !== 1'b0 || stall_req !== 1'b0) seen = 1'b1;
            tick();
        end
        chk("flush_div_quiet", {31'd0, seen}, 32'd0);
        chk("flush_div_hi_late", hi_o, 32'h11);

        // MULT issued mid-division is dropped.
        start = 1'b1; op = 3'd3; src_a = 32'd123456; src_b = 32'd789;
        tick();
        start = 1'b0;
        repeat (4) tick();
        start = 1'b1; op = 3'd0; src_a = 32'd3; src_b = 32'd3;
        tick();
        start = 1'b0;
        chk("mult_in_div_hi", hi_o, m_hi);
        chk("mult_in_div_lo", lo_o, m_lo);
        chk("mult_in_div_stall", {31'd0, stall_req}, 32'd1);
        finish_div("divu_busy", 3'd3, 32'd123456, 32'd789, 6);

        // Reset at DIV cycle 5 discards the division.
        start = 1'b1; op = 3'd2; src_a = 32'd50; src_b = 32'd3;
        tick();
        start = 1'b0;
        repeat (4) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_div_hi", hi_o, 32'd0);
        chk("rst_div_lo", lo_o, 32'd0);
        chk("rst_div_stall", {31'd0, stall_req}, 32'd0);
        chk("rst_div_done", {31'd0, done}, 32'd0);
        m_hi = '0;
        m_lo = '0;
        seen = 1'b0;
        repeat (40) begin
            if (done !== 1'b0 || hi_o !== 32'd0) seen = 1'b1;
            tick();
        end
        chk("rst_div_quiet", {31'd0, seen}, 32'd0);

        // Reset wins over a simultaneous request.
        rst = 1'b1; start = 1'b1; op = 3'd4; src_a = 32'hDEAD_BEEF;
        tick();
        rst = 1'b0; start = 1'b0;
        chk("rst_prio_hi", hi_o, 32'd0);

        for (int i = 0; i < 24; i++) begin
            r_op = 3'($urandom_range(0, 7));
            r_a  = $urandom;
            r_b  = $urandom;
            if ($urandom_range(0, 7) == 0) r_b = 32'd0;
            else if ($urandom_range(0, 3) == 0) r_b = 32'($urandom_range(1, 20));
            issue(r_op, r_a, r_b, $sformatf("rnd%0d_op%0d", i, r_op));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mdu_hilo_ctrl.md
MDU_HILO_CTRL -- requirements
Module: mdu_hilo_ctrl

Interface
REQ-001 Clocking SHALL use one clock; reset SHALL be synchronous and active-high.
REQ-002 Parameters: DIV_CYCLES, default 32, number of quotient iterations (fixed at 32 for 32-bit operands).
REQ-003 clk  in  1  sole clock, all state updates on its rising edge.
REQ-004 rst  in  1  synchronous active-high reset.
REQ-005 start  in  1  request valid from EX this cycle.
REQ-006 op  in  3  0=MULT, 1=MULTU, 2=DIV, 3=DIVU, 4=MTHI, 5=MTLO; 6,7 reserved, treated as no-op.
REQ-007 src_a  in  32  rs operand (dividend, multiplicand, or MTHI/MTLO data).
REQ-008 src_b  in  32  rt operand (divisor, multiplier).
REQ-009 flush  in  1  pipeline flush (exception or eret); cancels in-flight and same-cycle requests.
REQ-010 stall_req  out  1  pipeline stall request to hazard unit.
REQ-011 done  out  1  registered one-cycle pulse, HI/LO updated by a DIV/DIVU on the preceding edge.
REQ-012 hi_o  out  32  architectural HI register.
REQ-013 lo_o  out  32  architectural LO register.

Function
REQ-014 The FSM SHALL have states IDLE and DIV only.
REQ-015 An accept SHALL occur when start=1, flush=0, state=IDLE, and op is not reserved; otherwise start SHALL be ignored.
REQ-016 An accepted MTHI SHALL load hi_o<=src_a at the next edge; lo_o is unchanged; stall_req=0.
REQ-017 An accepted MTLO SHALL load lo_o<=src_a at the next edge; hi_o is unchanged; stall_req=0.
REQ-018 An accepted MULT/MULTU SHALL load {hi_o,lo_o}<=signed/unsigned 64-bit product at the next edge; stall_req=0; done stays 0.
REQ-019 An accepted DIV/DIVU SHALL assert stall_req combinationally in the accept cycle, enter DIV, clear the iteration counter, and latch operand magnitudes and sign flags.
REQ-020 In DIV, one restoring radix-2 step SHALL complete per cycle; stall_req SHALL be 1 throughout DIV.
REQ-021 At the edge completing step DIV_CYCLES, hi_o<=remainder and lo_o<=quotient, the FSM SHALL return to IDLE, and done SHALL be 1 in the following cycle only.
REQ-022 Total stall SHALL be 33 cycles: the accept cycle plus 32 DIV cycles.
REQ-023 Signed results: quotient negative iff operand signs differ; remainder SHALL take the dividend's sign.
REQ-024 Divide by zero (src_b=0), signed or unsigned, SHALL take the full 33 cycles and then write hi_o=src_a and lo_o=32'hFFFFFFFF.
REQ-025 Signed overflow 0x80000000 / 0xFFFFFFFF SHALL write lo_o=0x80000000 and hi_o=0.
REQ-026 flush=1 in DIV SHALL return the FSM to IDLE at the next edge with hi_o/lo_o unchanged and done=0; stall_req SHALL drop in the cycle after the flush.
REQ-027 start asserted during DIV SHALL be ignored, with no queuing.
REQ-028 Reserved op values SHALL leave all state unchanged.

Reset
REQ-029 rst=1 SHALL force state=IDLE, counter=0, hi_o=0, lo_o=0, done=0, and stall_req=0 from the next edge; rst SHALL take priority over flush and start.
REQ-030 rst asserted mid-division SHALL discard the operation without writing HI/LO.

Structure
REQ-031 The op encodings, the state encoding, and DIV_CYCLES SHALL reside in the shared defines package.
REQ-032 The iterative divider datapath (shift/subtract, counter, sign fix-up) SHALL be a sub-module named mdu_div_core with start/abort/done handshake; the FSM, multiplier, and HI/LO registers SHALL stay in mdu_hilo_ctrl.

Verification
REQ-033 MULTU src_a=0xFFFFFFFF, src_b=2 -> next cycle hi_o=0x00000001, lo_o=0xFFFFFFFE; stall_req never 1.
REQ-034 DIV src_a=-7 (0xFFFFFFF9), src_b=2 -> stall_req high 33 cycles, then lo_o=0xFFFFFFFD, hi_o=0xFFFFFFFF, done pulses once.
REQ-035 DIVU src_a=100, src_b=0 -> after 33 cycles hi_o=100, lo_o=0xFFFFFFFF.
REQ-036 DIV started with hi_o=0x11, lo_o=0x22; flush at cycle 10 -> IDLE next edge, hi_o=0x11, lo_o=0x22, done=0.
REQ-037 MTHI 0xA5A5A5A5 then MTLO 0x5A5A5A5A in back-to-back cycles -> hi_o=0xA5A5A5A5, lo_o=0x5A5A5A5A; MULT issued during a DIV is ignored.
REQ-038 rst at DIV cycle 5 -> next cycle hi_o=lo_o=0, stall_req=0, state=IDLE.
